twiddle_loader32: RTL and testbench
===================================

// Module: twiddle_loader32
// PURPOSE
//  Writable twiddle store for the 32-point FFT pipeline: the write-side counterpart of the fixed twiddle ROM.
//  A host or boot sequencer writes 32 complex twiddles (NB-bit sfp, real+imag) one per handshake.
//  The block packs them into 8 rows of 4 lanes, then replays rows on START in the butterfly schedule.
//  Its OR/OI/RDY outputs drop into the butterfly datapath where the ROM outputs sit today.
// PARAMETERS
//  NB      9    twiddle word width (sfp format, matches `FFTsfpw nb)
// PORTS
//  CLK        in   1     clock; all logic on rising edge
//  RST        in   1     synchronous, active-high reset
//  WR_VALID   in   1     write request
//  WR_READY   out  1     write accepted when WR_VALID&WR_READY at CLK edge
//  WR_IDX     in   5     twiddle index 0..31
//  WR_RE      in   NB    real part
//  WR_IM      in   NB    imag part
//  LOAD_DONE  out  1     all 32 indices written since reset
//  START      in   1     start playback (1-cycle pulse)
//  STAGE      in   1     schedule select; sampled with START
//  OR         out  4*NB  real lanes {w[4r+3],w[4r+2],w[4r+1],w[4r]}
//  OI         out  4*NB  imag lanes, same packing
//  RDY        out  1     high on first cycle each new row is on OR/OI
//  DONE       out  1     1-cycle pulse after last playback cycle
//  ERR        out  1     1-cycle pulse: START rejected (table incomplete)
// BEHAVIOUR
//  Reset: state=LOAD, valid bitmap=0, OR=OI=0, RDY=DONE=ERR=0, WR_READY=1, LOAD_DONE=0; memory not cleared.
//  States: LOAD (bitmap incomplete), READY (bitmap full, idle), PLAY.
//  Write: accepted in LOAD/READY (WR_READY=state!=PLAY, registered).
//   Entry stored at row WR_IDX[4:2], lane WR_IDX[1:0]; sets bitmap bit WR_IDX.
//   Rewriting an index overwrites it; no error.
//  LOAD->READY: on the edge the bitmap becomes all-ones. LOAD_DONE=1 from that edge until reset.
//  START in LOAD: ignored, ERR pulses next cycle; state unchanged.
//  START in READY: latch STAGE, cnt<=0, ->PLAY.
//   Write on the same edge commits first; playback sees new data.
//  PLAY: each edge OR/OI <= row map(cnt[4:2]); RDY<=(cnt[1:0]==0); cnt<=cnt+1.
//   Row map: STAGE0 -> row=g; STAGE1 -> row = g[0] ? 4 : 0, where g=cnt[4:2].
//   Each row is held 4 cycles; 8 groups = 32 cycles.
//   First row is valid one edge after the START edge.
//   At cnt=31: row 7 issued, ->READY; DONE pulses the cycle after.
//   OR/OI hold the last row until the next playback.
//  START during PLAY restarts: cnt<=0, STAGE re-latched, no ERR.
//  WR_VALID during PLAY: not accepted; host holds data until WR_READY.
//  RST mid-PLAY: immediate return to reset state. Bitmap cleared, so a reload is required.
//  RDY, DONE and ERR are single-cycle pulses.
// TESTING
//  1 Reset, write idx i with RE=i, IM=i+256 for i=0..31 -> LOAD_DONE rises on 32nd accept; WR_READY stays 1.
//  2 START with STAGE=0 -> rows 0..7, 4 cycles each; row1 OR={9'd7,9'd6,9'd5,9'd4}.
//    RDY at cycles 1,5,...,29; DONE at cycle 33.
//  3 START with STAGE=1 -> row sequence 0,4,0,4,0,4,0,4; OI row4={9'd275,9'd274,9'd273,9'd272}.
//  4 START after writing only 31 indices -> ERR pulse, no RDY, OR/OI unchanged.
//    Write the missing index, then START -> normal playback.
//  5 Hold WR_VALID (idx 5, RE=0x1FF) during PLAY -> WR_READY=0 until DONE.
//    Accepted after; next playback row1 lane1 = 0x1FF.
//  6 Assert RST at playback cycle 10 -> OR=OI=0, LOAD_DONE=0, state LOAD. START -> ERR.

Source files
------------

// File: rtl/twiddle_loader32.sv
`timescale 1ns/1ps
// Writable 32-entry complex twiddle store packed as 8 rows x 4 lanes,
// replayed row by row in the butterfly schedule on START.
module twiddle_loader32 #(
    parameter int NB = 9
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WR_VALID,
    output logic            WR_READY,
    input  logic [4:0]      WR_IDX,
    input  logic [NB-1:0]   WR_RE,
    input  logic [NB-1:0]   WR_IM,
    output logic            LOAD_DONE,
    input  logic            START,
    input  logic            STAGE,
    output logic [4*NB-1:0] OR,
    output logic [4*NB-1:0] OI,
    output logic            RDY,
    output logic            DONE,
    output logic            ERR
);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_PLAY} state_t;

    state_t      state_reg;
    logic [31:0] valid_reg;
    logic [31:0] valid_next;
    logic [4:0]  cnt_reg;
    logic        stage_reg;
    logic        last_reg;
    logic        ready_reg;
    logic        load_done_reg;
    logic        rdy_reg;
    logic        done_reg;
    logic        err_reg;

    logic        wr_fire;
    logic        play_issue;
    logic [2:0]  grp;
    logic [2:0]  rd_row;

    always_comb begin
        wr_fire    = WR_VALID & ready_reg;
        valid_next = valid_reg;
        if (wr_fire)
            valid_next = valid_reg | (32'd1 << WR_IDX);
        // A START seen in PLAY restarts the schedule instead of issuing a row.
        play_issue = (state_reg == S_PLAY) && !START;
        grp        = cnt_reg[4:2];
        rd_row     = grp;
        if (stage_reg)
            rd_row = grp[0] ? 3'd4 : 3'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_LOAD;
            valid_reg     <= '0;
            cnt_reg       <= '0;
            stage_reg     <= 1'b0;
            last_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            load_done_reg <= 1'b0;
            rdy_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            rdy_reg   <= 1'b0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= last_reg;
            case (state_reg)
                S_LOAD: begin
                    if (START)
                        err_reg <= 1'b1;
                    if (&valid_next) begin
                        state_reg     <= S_READY;
                        load_done_reg <= 1'b1;
                    end
                end
                S_READY: begin
                    if (START) begin
                        stage_reg <= STAGE;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (START) begin
                        stage_reg <= STAGE;
                        cnt_reg   <= '0;
                    end else begin
                        rdy_reg <= (cnt_reg[1:0] == 2'd0);
                        cnt_reg <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31) begin
                            state_reg <= S_READY;
                            ready_reg <= 1'b1;
                            last_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= S_LOAD;
            endcase
        end
    end

    // One RAM per lane; the lane output register doubles as the OR/OI holding register.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [NB-1:0] mem_re [0:7];
            logic [NB-1:0] mem_im [0:7];
            logic [NB-1:0] out_re_reg;
            logic [NB-1:0] out_im_reg;

            always_ff @(posedge CLK) begin
                if (wr_fire && (WR_IDX[1:0] == 2'(gi))) begin
                    mem_re[WR_IDX[4:2]] <= WR_RE;
                    mem_im[WR_IDX[4:2]] <= WR_IM;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    out_re_reg <= '0;
                    out_im_reg <= '0;
                end else if (play_issue) begin
                    out_re_reg <= mem_re[rd_row];
                    out_im_reg <= mem_im[rd_row];
                end
            end

            assign OR[gi*NB +: NB] = out_re_reg;
            assign OI[gi*NB +: NB] = out_im_reg;
        end
    endgenerate

    assign WR_READY  = ready_reg;
    assign LOAD_DONE = load_done_reg;
    assign RDY       = rdy_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

endmodule

// File: tb/tb_twiddle_loader32.sv
`timescale 1ns/1ps
// Directed bench for twiddle_loader32: a reference table model feeds a queue
// of expected rows at each START; rows are popped on the expected schedule.
module tb_twiddle_loader32;

    localparam int NB = 9;

    logic            CLK = 1'b0;
    logic            RST;
    logic            WR_VALID;
    logic            WR_READY;
    logic [4:0]      WR_IDX;
    logic [NB-1:0]   WR_RE;
    logic [NB-1:0]   WR_IM;
    logic            LOAD_DONE;
    logic            START;
    logic            STAGE;
    logic [4*NB-1:0] OR;
    logic [4*NB-1:0] OI;
    logic            RDY;
    logic            DONE;
    logic            ERR;

    int checks   = 0;
    int failures = 0;

    logic [NB-1:0]     m_re [32];
    logic [NB-1:0]     m_im [32];
    logic [8*NB-1:0]   exp_q [$];

    always #5 CLK = ~CLK;

    twiddle_loader32 #(.NB(NB)) dut (
        .CLK(CLK), .RST(RST),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_IDX(WR_IDX),
        .WR_RE(WR_RE), .WR_IM(WR_IM), .LOAD_DONE(LOAD_DONE),
        .START(START), .STAGE(STAGE),
        .OR(OR), .OI(OI), .RDY(RDY), .DONE(DONE), .ERR(ERR)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] exp_row(input int r);
        logic [4*NB-1:0] ore;
        logic [4*NB-1:0] oim;
        for (int l = 0; l < 4; l++) begin
            ore[l*NB +: NB] = m_re[4*r+l];
            oim[l*NB +: NB] = m_im[4*r+l];
        end
        return {ore, oim};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic write_word(input logic [4:0] idx, input logic [NB-1:0] re, input logic [NB-1:0] im);
        int waited = 0;
        WR_VALID = 1'b1; WR_IDX = idx; WR_RE = re; WR_IM = im;
        while (!WR_READY && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        check("wr_ready_wait", (waited < 100), 1'b1);
        @(negedge CLK);
        WR_VALID = 1'b0;
        m_re[idx] = re;
        m_im[idx] = im;
    endtask

    // Full playback; cycle c is the period after the c-th edge following the START edge.
    task automatic play(input logic stg, input bit hold_wr, input logic [4:0] widx,
                        input logic [NB-1:0] wre, input logic [NB-1:0] wim);
        logic [8*NB-1:0] cur;
        START = 1'b1; STAGE = stg;
        for (int g = 0; g < 8; g++)
            exp_q.push_back(exp_row(stg ? ((g % 2) ? 4 : 0) : g));
        @(negedge CLK);
        START = 1'b0; STAGE = 1'b0;
        if (hold_wr) begin
            WR_VALID = 1'b1; WR_IDX = widx; WR_RE = wre; WR_IM = wim;
        end
        cur = '0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge CLK);
            if (c <= 29 && ((c - 1) % 4) == 0 && exp_q.size() > 0)
                cur = exp_q.pop_front();
            check($sformatf("rdy c%0d", c), RDY, (c <= 29 && ((c - 1) % 4) == 0));
            check($sformatf("row c%0d", c), {OR, OI}, cur);
            check($sformatf("done c%0d", c), DONE, (c == 33));
            check($sformatf("wr_ready c%0d", c), WR_READY, (c >= 32));
            if (hold_wr && c == 32) begin
                m_re[widx] = wre;
                m_im[widx] = wim;
            end
            if (hold_wr && c == 33)
                WR_VALID = 1'b0;
        end
        $display("play stage=%0d hold_wr=%0d done", stg, hold_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; WR_VALID = 1'b0; WR_IDX = '0; WR_RE = '0; WR_IM = '0;
        START = 1'b0; STAGE = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst OR", OR, '0);
        check("rst OI", OI, '0);
        check("rst RDY", RDY, 1'b0);
        check("rst DONE", DONE, 1'b0);
        check("rst ERR", ERR, 1'b0);
        check("rst WR_READY", WR_READY, 1'b1);
        check("rst LOAD_DONE", LOAD_DONE, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Load RE=i, IM=i+256
        for (int i = 0; i < 32; i++) begin
            write_word(5'(i), NB'(i), NB'(i + 256));
            check($sformatf("load_done i%0d", i), LOAD_DONE, (i == 31));
            check($sformatf("wr_ready i%0d", i), WR_READY, 1'b1);
            $display("write idx=%0d re=%0d im=%0d", i, i, i + 256);
        end

        play(1'b0, 1'b0, 5'd0, '0, '0);
        check("row1 lanes", exp_row(1), {9'd7, 9'd6, 9'd5, 9'd4, 9'd263, 9'd262, 9'd261, 9'd260});
        play(1'b1, 1'b0, 5'd0, '0, '0);
        check("row4 OI lanes", exp_row(4), {9'd19, 9'd18, 9'd17, 9'd16, 9'd275, 9'd274, 9'd273, 9'd272});

        // Write held across playback, accepted only once WR_READY returns
        play(1'b0, 1'b1, 5'd5, 9'h1FF, 9'h0AB);
        play(1'b0, 1'b0, 5'd0, '0, '0);
        check("row1 lane1 after held write", m_re[5], 9'h1FF);

        // Reset in the middle of playback
        START = 1'b1; STAGE = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst OR", OR, '0);
        check("midrst OI", OI, '0);
        check("midrst LOAD_DONE", LOAD_DONE, 1'b0);
        check("midrst WR_READY", WR_READY, 1'b1);
        check("midrst RDY", RDY, 1'b0);
        RST = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("midrst ERR", ERR, 1'b1);
        for (int c = 0; c < 36; c++) begin
            @(negedge CLK);
            check($sformatf("midrst quiet c%0d", c), {ERR, RDY, DONE}, 3'b000);
        end
        $display("reset during playback done");

        // Incomplete table: all but index 17
        for (int i = 0; i < 32; i++) begin
            if (i != 17)
                write_word(5'(i), NB'(i + 32), NB'(i + 100));
        end
        check("31 words LOAD_DONE", LOAD_DONE, 1'b0);
        START = 1'b1; STAGE = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        check("incomplete ERR", ERR, 1'b1);
        check("incomplete RDY", RDY, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check($sformatf("incomplete hold c%0d", c), {ERR, RDY, OR, OI}, '0);
        end
        $display("START rejected with 31 words");
        write_word(5'd17, 9'd49, 9'd117);
        check("32 words LOAD_DONE", LOAD_DONE, 1'b1);
        play(1'b0, 1'b0, 5'd0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
